// File: rtl/pulse_measure.sv
// Pulse width / period measurement.
// Consumes single-cycle rise/down edge pulses from an upstream edge detector,
// measures high time and rise-to-rise period in clk cycles, and presents each
// completed result in a one-entry valid/ready output register. Sticky flags
// report dropped results (ovf) and edge-protocol violations (err).
module pulse_measure #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rise,
    input  logic             down,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             meas_sat,
    output logic             ovf,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_reg;
    // cnt_reg holds (current cycle - t0), clamped at CNT_MAX
    logic [CNT_W-1:0] cnt_reg;
    // set once the count would have gone past CNT_MAX
    logic             cnt_sat_reg;
    logic [CNT_W-1:0] width_cap_reg;
    logic             width_sat_reg;
    logic             err_reg;

    logic             valid_reg;
    logic [CNT_W-1:0] width_reg;
    logic [CNT_W-1:0] period_reg;
    logic             sat_reg;
    logic             ovf_reg;

    logic both_edges;
    logic rise_only;
    logic down_only;
    logic complete;
    logic accept;
    logic can_load;

    // Edge qualification and output handshake decode
    always_comb begin
        both_edges = rise & down;
        rise_only  = rise & ~down;
        down_only  = down & ~rise;
        complete   = (state_reg == LOW) && rise_only;
        accept     = valid_reg & meas_ready;
        // A new result may load if the slot is empty or is being emptied now
        can_load   = ~valid_reg | meas_ready;
    end

    // Measurement state machine, saturating cycle counter and width capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cnt_sat_reg   <= 1'b0;
            width_cap_reg <= '0;
            width_sat_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            // Free-running count while a measurement is open; restarts below override it
            if (state_reg != IDLE) begin
                if (cnt_reg == CNT_MAX) begin
                    cnt_sat_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end

            if (both_edges) begin
                // Ambiguous edge pair: flag it and leave the measurement untouched
                err_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rise_only) begin
                            state_reg   <= HIGH;
                            cnt_reg     <= CNT_ONE;
                            cnt_sat_reg <= 1'b0;
                        end
                    end
                    HIGH: begin
                        if (rise_only) begin
                            // Missing down: abandon this measurement and restart at this edge
                            err_reg     <= 1'b1;
                            cnt_reg     <= CNT_ONE;
                            cnt_sat_reg <= 1'b0;
                        end else if (down_only) begin
                            width_cap_reg <= cnt_reg;
                            width_sat_reg <= cnt_sat_reg;
                            state_reg     <= LOW;
                        end
                    end
                    LOW: begin
                        if (rise_only) begin
                            // Period closes here and the next measurement opens on the same edge
                            state_reg   <= HIGH;
                            cnt_reg     <= CNT_ONE;
                            cnt_sat_reg <= 1'b0;
                        end else if (down_only) begin
                            err_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    // One-entry result register with valid/ready handshake and overflow tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            width_reg  <= '0;
            period_reg <= '0;
            sat_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (complete) begin
            if (can_load) begin
                valid_reg  <= 1'b1;
                width_reg  <= width_cap_reg;
                period_reg <= cnt_reg;
                sat_reg    <= width_sat_reg | cnt_sat_reg;
            end else begin
                // Held result is not being taken: keep it and drop the new one
                ovf_reg <= 1'b1;
            end
        end else if (accept) begin
            valid_reg <= 1'b0;
        end
    end

    assign meas_valid = valid_reg;
    assign width      = width_reg;
    assign period     = period_reg;
    assign meas_sat   = sat_reg;
    assign ovf        = ovf_reg;
    assign err        = err_reg;

endmodule

// File: doc/pulse_measure.md
PULSE_MEASURE -- requirements
Module: pulse_measure

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width in bits of the width and period counters and results.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rise, input, 1 bit: one-cycle pulse marking a 0->1 edge of the monitored signal, driven by the upstream edge detector.
REQ-005 SHALL have port down, input, 1 bit: one-cycle pulse marking a 1->0 edge of the monitored signal.
REQ-006 SHALL have port meas_valid, output, 1 bit: a result is held on width/period/meas_sat.
REQ-007 SHALL have port meas_ready, input, 1 bit: the consumer accepts the result when meas_valid=1 and meas_ready=1 in the same cycle.
REQ-008 SHALL have port width, output, CNT_W bits: high time in clk cycles, from the rise pulse to the down pulse.
REQ-009 SHALL have port period, output, CNT_W bits: clk cycles from a rise pulse to the next rise pulse.
REQ-010 SHALL have port meas_sat, output, 1 bit: width or period saturated for this result.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag; a completed result was dropped.
REQ-012 SHALL have port err, output, 1 bit: sticky flag; an edge-protocol violation occurred.

Function
REQ-013 SHALL implement a state machine with states IDLE, HIGH and LOW; IDLE is entered after reset.
REQ-014 In IDLE, rise SHALL move the state to HIGH and start a measurement at that cycle (t0); down SHALL be ignored.
REQ-015 In HIGH, down at cycle t1 SHALL capture width = t1 - t0 internally and move the state to LOW.
REQ-016 In LOW, rise at cycle t2 SHALL complete the result (period = t2 - t0), move the state to HIGH and start a new measurement with t0 = t2, so that measurement is back-to-back.
REQ-017 Width and period counts SHALL saturate at 2^CNT_W-1 without wrapping; any saturation SHALL set meas_sat for that result.
REQ-018 A completed result SHALL appear on the outputs with meas_valid=1 in cycle t2+1 (one-cycle registered latency).
REQ-019 The output SHALL be a one-entry register; width, period and meas_sat SHALL remain stable while meas_valid=1 and meas_ready=0.
REQ-020 meas_valid SHALL clear the cycle after acceptance unless a new result loads in that same cycle.
REQ-021 If a result completes in the same cycle the held result is accepted, the new result SHALL load and meas_valid SHALL stay 1, with no ovf.
REQ-022 If a result completes while meas_valid=1 and meas_ready=0, the new result SHALL be dropped and ovf SHALL be set; the held result SHALL be unchanged.
REQ-023 A rise in HIGH (missing down) SHALL set err, discard the measurement in progress and restart HIGH with t0 at this cycle.
REQ-024 A down in LOW SHALL set err and be otherwise ignored.
REQ-025 rise and down asserted in the same cycle SHALL set err; both SHALL be ignored and the state SHALL be unchanged.
REQ-026 ovf and err SHALL clear only on reset.

Reset
REQ-027 When rst=1 at a clk edge, the state SHALL go to IDLE and counters SHALL clear.
REQ-028 When rst=1 at a clk edge, meas_valid, width, period, meas_sat, ovf and err SHALL all be 0 in the following cycle.
REQ-029 Reset SHALL take priority over all other inputs, including mid-measurement and while a result is pending; a pending result SHALL be discarded.

Verification
REQ-030 CNT_W=16, meas_ready=1; rise@10, down@13, rise@20 -> meas_valid=1 @21 with width=3, period=10, meas_sat=0, for one cycle.
REQ-031 meas_ready=0; two full periods complete -> first result held stable, second dropped, ovf=1; then meas_ready=1 -> first result accepted, meas_valid=0 next cycle.
REQ-032 CNT_W=4; rise@0, down@20, rise@30 -> width=15, period=15, meas_sat=1.
REQ-033 rise@10, rise@15 (no down) -> err=1 and no result; then down@18, rise@25 -> width=3, period=10.
REQ-034 rst=1 one cycle while in HIGH -> all outputs 0 next cycle; a following down is ignored; the next rise starts a fresh measurement.
REQ-035 meas_valid=1 and meas_ready=1 in the same cycle a new result completes -> new values appear, meas_valid stays 1, ovf=0.
